// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
// Shares one integer ALU between the two issue lanes. Each cycle the arbiter
// picks at most one lane (round-robin when both request) and drives that
// lane's fields to the ALU. It captures the ALU's same-cycle result in a
// one-entry response buffer that the writeback/branch consumer drains.
//
// Optional build macro: ALU_ARB_STATS_EN adds 32-bit grant/stall counters
// (grant_cnt_0, grant_cnt_1, stall_cnt). Without it the ports and counters do
// not exist and the rest of the behaviour is unchanged.
//
// Handshake rules, request and response side alike:
//   - A transfer happens on a rising edge where valid && ready.
//   - ready may depend on valid, but valid never depends on ready.
//   - A producer holds valid and its payload stable while valid && !ready.

module alu_issue_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP    = 4,
    parameter int unsigned TAG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    // Issue lane 0
    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic [WIDTH-1:0] req_rs1_0,
    input  logic [WIDTH-1:0] req_rs2_0,
    input  logic [OP-1:0]    req_op_0,
    input  logic [4:0]       req_shamt_0,
    input  logic [TAG-1:0]   req_tag_0,

    // Issue lane 1
    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic [WIDTH-1:0] req_rs1_1,
    input  logic [WIDTH-1:0] req_rs2_1,
    input  logic [OP-1:0]    req_op_1,
    input  logic [4:0]       req_shamt_1,
    input  logic [TAG-1:0]   req_tag_1,

    // Shared ALU (purely combinational on the far side)
    output logic [WIDTH-1:0] alu_rs1,
    output logic [WIDTH-1:0] alu_rs2,
    output logic [OP-1:0]    alu_op,
    output logic [4:0]       alu_shamt,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_branch,

    // Response buffer towards writeback / branch resolution
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_lane,
    output logic [TAG-1:0]   rsp_tag,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_branch,
    output logic             rsp_illegal
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]      grant_cnt_0,
    output logic [31:0]      grant_cnt_1,
    output logic [31:0]      stall_cnt
`endif
);

    // Opcodes 0..13 are implemented by the ALU; anything above is illegal.
    localparam logic [OP-1:0] LAST_LEGAL_OP = OP'(13);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             prio_q,        prio_d;        // lane that wins a tie
    logic             rsp_valid_q,   rsp_valid_d;
    logic             rsp_lane_q,    rsp_lane_d;
    logic [TAG-1:0]   rsp_tag_q,     rsp_tag_d;
    logic [WIDTH-1:0] rsp_result_q,  rsp_result_d;
    logic             rsp_branch_q,  rsp_branch_d;
    logic             rsp_illegal_q, rsp_illegal_d;

    // ------------------------------------------------------------------
    // Arbitration signals
    // ------------------------------------------------------------------
    logic             any_valid;
    logic             grant_lane;
    logic             can_accept;
    logic             accept;
    logic [TAG-1:0]   sel_tag;
    logic             op_illegal;

    // Pick the lane: a lone requester always wins, a tie goes to prio_q.
    always_comb begin
        any_valid  = req_valid_0 | req_valid_1;
        grant_lane = 1'b0;
        if (req_valid_0 && req_valid_1) begin
            grant_lane = prio_q;
        end else begin
            grant_lane = req_valid_1;
        end
    end

    // The buffer can take a new result when empty or being drained this cycle.
    always_comb begin
        can_accept  = !rsp_valid_q || rsp_ready;
        accept      = can_accept && any_valid;
        req_ready_0 = accept && !grant_lane;
        req_ready_1 = accept &&  grant_lane;
    end

    // Route the granted lane to the ALU; idle ALU sees all-zero (add 0,0).
    always_comb begin
        alu_rs1   = '0;
        alu_rs2   = '0;
        alu_op    = '0;
        alu_shamt = '0;
        sel_tag   = '0;
        if (any_valid) begin
            if (grant_lane) begin
                alu_rs1   = req_rs1_1;
                alu_rs2   = req_rs2_1;
                alu_op    = req_op_1;
                alu_shamt = req_shamt_1;
                sel_tag   = req_tag_1;
            end else begin
                alu_rs1   = req_rs1_0;
                alu_rs2   = req_rs2_0;
                alu_op    = req_op_0;
                alu_shamt = req_shamt_0;
                sel_tag   = req_tag_0;
            end
        end
    end

    // Flag opcodes the ALU does not implement; their result is discarded.
    always_comb begin
        op_illegal = any_valid && (alu_op > LAST_LEGAL_OP);
    end

    // Next-state for the response buffer and the round-robin pointer.
    always_comb begin
        prio_d        = prio_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_lane_d    = rsp_lane_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_result_d  = rsp_result_q;
        rsp_branch_d  = rsp_branch_q;
        rsp_illegal_d = rsp_illegal_q;

        if (accept) begin
            // Loser of this grant becomes favourite for the next tie.
            prio_d        = ~grant_lane;
            rsp_valid_d   = 1'b1;
            rsp_lane_d    = grant_lane;
            rsp_tag_d     = sel_tag;
            rsp_result_d  = op_illegal ? '0   : alu_result;
            rsp_branch_d  = op_illegal ? 1'b0 : alu_branch;
            rsp_illegal_d = op_illegal;
        end else if (rsp_ready) begin
            // Drained with nothing new arriving: buffer empties, payload kept.
            rsp_valid_d   = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_lane_q    <= 1'b0;
            rsp_tag_q     <= '0;
            rsp_result_q  <= '0;
            rsp_branch_q  <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            prio_q        <= prio_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_lane_q    <= rsp_lane_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_result_q  <= rsp_result_d;
            rsp_branch_q  <= rsp_branch_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    // Response outputs come straight from the buffer registers.
    always_comb begin
        rsp_valid   = rsp_valid_q;
        rsp_lane    = rsp_lane_q;
        rsp_tag     = rsp_tag_q;
        rsp_result  = rsp_result_q;
        rsp_branch  = rsp_branch_q;
        rsp_illegal = rsp_illegal_q;
    end

`ifdef ALU_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: per-lane grants and cycles where a request went unserved
    // ------------------------------------------------------------------
    logic [31:0] grant_cnt_0_q, grant_cnt_0_d;
    logic [31:0] grant_cnt_1_q, grant_cnt_1_d;
    logic [31:0] stall_cnt_q,   stall_cnt_d;

    // Counter increments; all wrap naturally at 2^32.
    always_comb begin
        grant_cnt_0_d = grant_cnt_0_q;
        grant_cnt_1_d = grant_cnt_1_q;
        stall_cnt_d   = stall_cnt_q;
        if (req_ready_0) begin
            grant_cnt_0_d = grant_cnt_0_q + 32'd1;
        end
        if (req_ready_1) begin
            grant_cnt_1_d = grant_cnt_1_q + 32'd1;
        end
        if (any_valid && !accept) begin
            stall_cnt_d   = stall_cnt_q + 32'd1;
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt_0_q <= '0;
            grant_cnt_1_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            grant_cnt_0_q <= grant_cnt_0_d;
            grant_cnt_1_q <= grant_cnt_1_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    // Expose the counters.
    always_comb begin
        grant_cnt_0 = grant_cnt_0_q;
        grant_cnt_1 = grant_cnt_1_q;
        stall_cnt   = stall_cnt_q;
    end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed scenarios followed by random traffic,
// with a reference model predicting grants and responses into a queue and a
// monitor popping that queue whenever the DUT presents a response.

module tb_alu_issue_arbiter;
  localparam int WIDTH = 32;
  localparam int OP    = 4;
  localparam int TAG   = 4;
  localparam int RW    = 1 + TAG + WIDTH + 2;  // {lane, tag, result, branch, illegal}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic             req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic             req_ready_0, req_ready_1;
  logic [WIDTH-1:0] req_rs1_0 = '0, req_rs2_0 = '0, req_rs1_1 = '0, req_rs2_1 = '0;
  logic [OP-1:0]    req_op_0 = '0, req_op_1 = '0;
  logic [4:0]       req_shamt_0 = '0, req_shamt_1 = '0;
  logic [TAG-1:0]   req_tag_0 = '0, req_tag_1 = '0;
  logic [WIDTH-1:0] alu_rs1, alu_rs2, alu_result;
  logic [OP-1:0]    alu_op;
  logic [4:0]       alu_shamt;
  logic             alu_branch;
  logic             rsp_valid, rsp_lane, rsp_branch, rsp_illegal;
  logic             rsp_ready = 1'b0;
  logic [TAG-1:0]   rsp_tag;
  logic [WIDTH-1:0] rsp_result;
`ifdef ALU_ARB_STATS_EN
  logic [31:0]      grant_cnt_0, grant_cnt_1, stall_cnt;
`endif

  alu_issue_arbiter #(.WIDTH(WIDTH), .OP(OP), .TAG(TAG)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
    .req_rs1_0(req_rs1_0), .req_rs2_0(req_rs2_0), .req_op_0(req_op_0),
    .req_shamt_0(req_shamt_0), .req_tag_0(req_tag_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
    .req_rs1_1(req_rs1_1), .req_rs2_1(req_rs2_1), .req_op_1(req_op_1),
    .req_shamt_1(req_shamt_1), .req_tag_1(req_tag_1),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_branch(alu_branch),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lane(rsp_lane),
    .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_branch(rsp_branch),
    .rsp_illegal(rsp_illegal)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1), .stall_cnt(stall_cnt)
`endif
  );

  // ---------------- ALU behaviour (external block) ----------------
  // Returns {branch, result}. Unimplemented opcodes produce junk so the
  // arbiter's forcing to zero is visible.
  function automatic logic [WIDTH:0] alu_fn(input logic [OP-1:0] op, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b, input logic [4:0] sh);
    logic [WIDTH-1:0] r;
    logic br;
    r  = '0;
    br = 1'b0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << sh;
      4'd6:  r = a >> sh;
      4'd7:  r = WIDTH'($signed(a) >>> sh);
      4'd8:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9:  r = {{(WIDTH-1){1'b0}}, (a < b)};
      4'd10: begin r = a - b; br = (a == b); end
      4'd11: begin r = a - b; br = (a != b); end
      4'd12: begin r = a - b; br = ($signed(a) < $signed(b)); end
      4'd13: begin r = a - b; br = ($signed(a) >= $signed(b)); end
      default: begin r = 32'hDEAD_BEEF; br = 1'b1; end
    endcase
    return {br, r};
  endfunction

  always_comb {alu_branch, alu_result} = alu_fn(alu_op, alu_rs1, alu_rs2, alu_shamt);

  // Expected buffer contents for a request accepted from a given lane.
  function automatic logic [RW-1:0] expect_of(input logic lane, input logic [OP-1:0] op,
                                              input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [4:0] sh, input logic [TAG-1:0] tag);
    logic [WIDTH:0] fr;
    if (op > 4'd13) return {lane, tag, {WIDTH{1'b0}}, 1'b0, 1'b1};
    fr = alu_fn(op, a, b, sh);
    return {lane, tag, fr[WIDTH-1:0], fr[WIDTH], 1'b0};
  endfunction

  // ---------------- scoreboard bookkeeping ----------------
  logic [RW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks buffer occupancy and the tie-break favourite as plain flags,
  // predicts which lane is served this cycle and queues the response.
  logic        m_prio = 1'b0, m_full = 1'b0;
  logic        m_acc0 = 1'b0, m_acc1 = 1'b0;
  logic [31:0] m_g0 = '0, m_g1 = '0, m_st = '0;
  logic        m_room, m_any, m_win;

  always @(negedge clk) begin : model
    if (!rst_n) begin
      exp_q.delete();
      m_prio = 1'b0; m_full = 1'b0; m_acc0 = 1'b0; m_acc1 = 1'b0;
      m_g0 = '0; m_g1 = '0; m_st = '0;
    end else begin
      m_room = !m_full || rsp_ready;
      m_any  = req_valid_0 || req_valid_1;
      m_win  = (req_valid_0 && req_valid_1) ? m_prio : req_valid_1;
      m_acc0 = m_room && m_any && !m_win;
      m_acc1 = m_room && m_any &&  m_win;
      check("req_ready_0", 64'(req_ready_0), 64'(m_acc0));
      check("req_ready_1", 64'(req_ready_1), 64'(m_acc1));
      check("rsp_valid", 64'(rsp_valid), 64'(m_full));
      if (!m_any)
        check("alu_idle_zero", 64'({alu_op, alu_shamt, alu_rs1 | alu_rs2}), 64'(0));
      if (m_acc0) begin
        exp_q.push_back(expect_of(1'b0, req_op_0, req_rs1_0, req_rs2_0, req_shamt_0, req_tag_0));
        m_g0++;
      end
      if (m_acc1) begin
        exp_q.push_back(expect_of(1'b1, req_op_1, req_rs1_1, req_rs2_1, req_shamt_1, req_tag_1));
        m_g1++;
      end
      if (m_any && !m_room) m_st++;
      if (m_acc0 || m_acc1) begin
        m_prio = m_acc0;  // the other lane is favoured next time
        m_full = 1'b1;
      end else if (rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'(0));
      end else begin
        check("rsp_fields", 64'({rsp_lane, rsp_tag, rsp_result, rsp_branch, rsp_illegal}),
              64'(exp_q[0]));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lane(input int lane, input logic v, input logic [OP-1:0] op,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [4:0] sh, input logic [TAG-1:0] tag);
    if (lane == 0) begin
      req_valid_0 = v; req_op_0 = op; req_rs1_0 = a; req_rs2_0 = b;
      req_shamt_0 = sh; req_tag_0 = tag;
    end else begin
      req_valid_1 = v; req_op_1 = op; req_rs1_1 = a; req_rs2_1 = b;
      req_shamt_1 = sh; req_tag_1 = tag;
    end
  endtask

  task automatic rand_lane(input int lane);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : WIDTH'($urandom);
    drive_lane(lane, 1'b1, OP'($urandom_range(0, 15)), a, b,
               5'($urandom_range(0, 31)), TAG'($urandom_range(0, 15)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_rsp_zero(input string name);
    check(name, 64'({rsp_valid, rsp_lane, rsp_tag, rsp_result, rsp_branch, rsp_illegal}), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  logic [RW-1:0] snap;

  initial begin
    // Reset state
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    check_rsp_zero("reset_state");

    // Single lane add: 5 + 7, tag 3
    step();
    rsp_ready = 1'b1;
    drive_lane(0, 1'b1, 4'd0, 32'd5, 32'd7, 5'd0, 4'd3);
    @(negedge clk);
    check("single_ready0", 64'(req_ready_0), 64'(1));
    step();
    req_valid_0 = 1'b0;
    @(negedge clk);
    check("single_rsp", 64'({rsp_valid, rsp_lane, rsp_tag, rsp_result}),
          64'({1'b1, 1'b0, 4'd3, 32'd12}));

    // Round-robin after reset: 0,1,0,1,0,1
    step();
    do_reset();
    rand_lane(0);
    rand_lane(1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_grant", 64'({req_ready_1, req_ready_0}), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      step();
      rand_lane(0);
      rand_lane(1);
    end

    // Backpressure: three held cycles, then release to the favoured lane 0
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready", 64'({req_ready_1, req_ready_0}), 64'(0));
      if (k == 0) snap = {rsp_lane, rsp_tag, rsp_result, rsp_branch, rsp_illegal};
      else check("bp_stable", 64'({rsp_lane, rsp_tag, rsp_result, rsp_branch, rsp_illegal}),
                 64'(snap));
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 64'({req_ready_1, req_ready_0}), 64'(2'b01));

    // Branch then illegal opcode on lane 1
    step();
    req_valid_0 = 1'b0;
    drive_lane(1, 1'b1, 4'd10, 32'd9, 32'd9, 5'd0, 4'd6);
    @(negedge clk);
    check("beq_ready1", 64'(req_ready_1), 64'(1));
    step();
    drive_lane(1, 1'b1, 4'd15, 32'h1234_5678, 32'h0000_0042, 5'd3, 4'd9);
    @(negedge clk);
    check("beq_rsp", 64'({rsp_valid, rsp_lane, rsp_branch}), 64'(3'b111));
    step();
    req_valid_1 = 1'b0;
    @(negedge clk);
    check("illegal_rsp", 64'({rsp_illegal, rsp_branch, rsp_result}), 64'({1'b1, 1'b0, 32'd0}));

    // Reset mid-flight: a held response is discarded and prio returns to lane 0
    step();
    rsp_ready = 1'b0;
    drive_lane(0, 1'b1, 4'd3, 32'hF0, 32'h0F, 5'd0, 4'd2);
    step();
    req_valid_0 = 1'b0;
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_pending", 64'(rsp_valid), 64'(1));
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_rsp_zero("mid_reset_rsp");
    step();
    rand_lane(0);
    rand_lane(1);
    @(negedge clk);
    check("mid_reset_prio", 64'({req_ready_1, req_ready_0}), 64'(2'b01));

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      step();
      rst_n = ($urandom_range(0, 499) != 0);
      if (!(req_valid_0 && !m_acc0)) begin
        if ($urandom_range(0, 3) != 0) rand_lane(0);
        else req_valid_0 = 1'b0;
      end
      if (!(req_valid_1 && !m_acc1)) begin
        if ($urandom_range(0, 3) != 0) rand_lane(1);
        else req_valid_1 = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain and final checks
    step();
    rst_n = 1'b1;
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'(0));
`ifdef ALU_ARB_STATS_EN
    check("grant_cnt_0", 64'(grant_cnt_0), 64'(m_g0));
    check("grant_cnt_1", 64'(grant_cnt_1), 64'(m_g1));
    check("stall_cnt", 64'(stall_cnt), 64'(m_st));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares the single integer ALU between the two issue lanes of the superscalar core. The arbiter accepts lane requests through valid/ready handshakes and grants round-robin. It drives the ALU combinationally from the granted lane and registers the result, tag and lane ID into a one-entry response buffer with backpressure. It sits between the issue stage and writeback/branch resolution.

## Interface
- WIDTH, 32, operand/result width
- OP, 4, ALU opcode width (encodings 0–13 legal, 14–15 illegal)
- TAG, 4, destination/ROB tag width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- req_valid_0 / req_valid_1  in  1  lane request valid
- req_ready_0 / req_ready_1  out  1  lane request accepted this cycle when valid&ready
- req_rs1_0/1, req_rs2_0/1  in  WIDTH  operands
- req_op_0/1  in  OP  opcode
- req_shamt_0/1  in  5  shift amount
- req_tag_0/1  in  TAG  tag
- alu_rs1, alu_rs2  out  WIDTH  operands to ALU
- alu_op  out  OP  opcode to ALU; 0 (add) when no grant
- alu_shamt  out  5  shift amount to ALU
- alu_result  in  WIDTH  ALU result (combinational, same cycle)
- alu_branch  in  1  ALU branch_control
- rsp_valid  out  1  response buffer holds a result
- rsp_ready  in  1  consumer takes response when valid&ready
- rsp_lane  out  1  originating lane
- rsp_tag  out  TAG  originating tag
- rsp_result  out  WIDTH  registered result; 0 when illegal
- rsp_branch  out  1  registered branch decision; 0 when illegal
- rsp_illegal  out  1  opcode was 14 or 15

## Operation
- can_accept = !rsp_valid || rsp_ready.
- Grant: both valid → lane prio; one valid → that lane; none → no grant.
- req_ready_i = can_accept && grant_i; ready may depend on valid, valid must never depend on ready.
- prio (1 bit, reset 0): on any accepted request, prio <= ~granted lane. Unchanged when nothing is accepted, including backpressure with both lanes valid.
- Mux to ALU: granted lane fields; with no grant, alu_* = 0.
- On accept: rsp_* <= {lane, tag, result, branch, illegal}; rsp_valid <= 1.
- Illegal op: result and branch are forced to 0 and illegal is set to 1. It is accepted and counts as a grant.
- Drain without accept: rsp_valid <= 0. Drain with accept in the same cycle: new response is loaded, rsp_valid stays 1.
- Requesters must hold fields stable while valid && !ready.

## Timing
- Latency: accept in cycle N → rsp_valid high in cycle N+1.
- Throughput: 1 op/cycle while rsp_ready=1; zero bubbles on drain+accept.
- Backpressure: rsp_valid && !rsp_ready → both req_ready_* = 0, rsp_* held unchanged.
- Fairness: with both lanes continuously valid and rsp_ready=1, grants alternate 0,1,0,1,…; each lane waits at most 1 grant.
- Reset, including mid-operation: rsp_valid=0, rsp_lane=0, rsp_tag=0, rsp_result=0, rsp_branch=0, rsp_illegal=0, prio=0. Any pending response is discarded. req_ready_* follow the combinational rule, so reset asserts ready for a valid lane.

## Configuration
- ALU_ARB_STATS_EN defined:
  - adds outputs grant_cnt_0, grant_cnt_1, stall_cnt, each 32 bits.
  - grant_cnt_i increments on each accept from lane i.
  - stall_cnt increments on each cycle with any req_valid high and no accept.
  - all counters wrap at 2^32, reset to 0.
- ALU_ARB_STATS_EN undefined: counters and ports absent; the rest of the behaviour is identical.

## Test plan
- Single lane: lane 0 valid, add rs1=5 rs2=7 tag=3 → req_ready_0=1 cycle N; cycle N+1 rsp_valid=1, rsp_result=12, rsp_lane=0, rsp_tag=3.
- Round-robin: both lanes valid 6 cycles after reset, rsp_ready=1 → grant order 0,1,0,1,0,1; rsp_lane matches that order one cycle later.
- Backpressure: fill response buffer, hold rsp_ready=0 for 3 cycles → req_ready_*=0, rsp_* stable, prio unchanged. Release → the next grant goes to the pending prio lane.
- Branch and illegal: lane 1 beq rs1=rs2=9 → rsp_branch=1. Lane 1 op=15 → rsp_illegal=1, rsp_result=0, rsp_branch=0.
- Reset mid-flight: rsp_valid=1, assert rst_n=0 one cycle → all rsp_* = 0, prio=0, and the next dual request is granted to lane 0.
- Stats (ALU_ARB_STATS_EN): 4 lane-0 accepts, 2 lane-1 accepts, 3 backpressured cycles with valid high → grant_cnt_0=4, grant_cnt_1=2, stall_cnt=3.
